// File: rtl/viewport_frame_scheduler.sv
// Frame-level raster scan controller: issues H_DISP x V_DISP fragment coordinates
// over valid/ready, paced by line credits returned from the downstream line buffer.
module viewport_frame_scheduler #(
  parameter int H_DISP       = 1280,
  parameter int V_DISP       = 720,
  parameter int LINE_CREDITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_req,
  input  logic        frame_abort,
  input  logic        line_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frag_x,
  output logic [15:0] frag_y,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] X_LAST   = 16'(H_DISP - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_DISP - 1);
  localparam logic [3:0]  CRED_MAX = 4'(LINE_CREDITS);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t      state, state_next;
  logic [15:0] x, x_next, y, y_next, cnt_next;
  logic [3:0]  credits, credits_next;
  logic        xfer, at_eol, at_eof, credit_take;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      credits   <= CRED_MAX;
      frame_cnt <= '0;
    end else begin
      state     <= state_next;
      x         <= x_next;
      y         <= y_next;
      credits   <= credits_next;
      frame_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    x_next       = x;
    y_next       = y;
    credits_next = credits;
    cnt_next     = frame_cnt;
    frame_done   = 1'b0;

    at_eol      = (x == X_LAST);
    at_eof      = at_eol && (y == Y_LAST);
    out_valid   = (state == SCAN) && (credits != 4'd0);
    sof         = out_valid && (x == 16'd0) && (y == 16'd0);
    eol         = out_valid && at_eol;
    eof         = out_valid && at_eof;
    busy        = (state != IDLE);
    frag_x      = x;
    frag_y      = y;
    xfer        = out_valid && out_ready;
    credit_take = xfer && at_eol;

    // A returning credit cancels the one consumed by an eol transfer in the same cycle.
    if (state != IDLE) begin
      if (credit_take) begin
        credits_next = line_ack ? credits : credits - 4'd1;
      end else if (line_ack && (credits != CRED_MAX)) begin
        credits_next = credits + 4'd1;
      end
    end

    case (state)
      IDLE: begin
        if (frame_req) begin
          state_next   = SCAN;
          x_next       = '0;
          y_next       = '0;
          credits_next = CRED_MAX;
        end
      end
      SCAN: begin
        if (xfer) begin
          if (at_eol) begin
            x_next = '0;
            if (at_eof) state_next = DRAIN;
            else        y_next     = y + 16'd1;
          end else begin
            x_next = x + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (credits == CRED_MAX) begin
          frame_done   = 1'b1;
          cnt_next     = frame_cnt + 16'd1;
          state_next   = IDLE;
          x_next       = '0;
          y_next       = '0;
          credits_next = CRED_MAX;
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides everything, including a completion in the same cycle.
    if (frame_abort) begin
      state_next   = IDLE;
      x_next       = '0;
      y_next       = '0;
      credits_next = CRED_MAX;
      cnt_next     = frame_cnt;
      frame_done   = 1'b0;
    end
  end

endmodule

// File: tb/tb_viewport_frame_scheduler.sv
// Randomized scoreboard bench for viewport_frame_scheduler on a 4x3 raster with two
// line credits; control outputs are predicted from an outstanding-lines model.
module tb_viewport_frame_scheduler;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int LC = 2;
  localparam int N  = H * V;

  logic        clk = 1'b0;
  logic        rst_n, frame_req, frame_abort, line_ack, out_ready;
  logic        out_valid, sof, eol, eof, busy, frame_done;
  logic [15:0] frag_x, frag_y, frame_cnt;

  always #5 clk = ~clk;

  viewport_frame_scheduler #(.H_DISP(H), .V_DISP(V), .LINE_CREDITS(LC)) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .frame_abort(frame_abort),
    .line_ack(line_ack), .out_valid(out_valid), .out_ready(out_ready),
    .frag_x(frag_x), .frag_y(frag_y), .sof(sof), .eol(eol), .eof(eof),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  pix_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  bit          m_active = 1'b0;
  int          m_issued = 0;
  int          m_out    = 0;
  logic [15:0] m_cnt    = '0;
  bit          stall_prev = 1'b0;
  logic [34:0] stall_snap = '0;
  int          ack_mode   = 1;
  logic [3:0]  ack_pipe   = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is active from accepted request to completion; lines outstanding
  // downstream throttle issue, and completion needs every line retired.
  always @(negedge clk) begin
    bit   exp_valid, exp_done, fire, eol_fire;
    pix_t item;
    if (rst_n !== 1'b1) begin
      m_active   = 1'b0;
      m_issued   = 0;
      m_out      = 0;
      m_cnt      = '0;
      stall_prev = 1'b0;
      sb.delete();
    end else begin
      exp_valid = m_active && (m_issued < N) && (m_out < LC);
      exp_done  = m_active && (m_issued == N) && (m_out == 0) && !frame_abort;
      checkOutput("busy",       64'(busy),       64'(m_active));
      checkOutput("out_valid",  64'(out_valid),  64'(exp_valid));
      checkOutput("frame_done", 64'(frame_done), 64'(exp_done));
      checkOutput("frame_cnt",  64'(frame_cnt),  64'(m_cnt));
      if (stall_prev)
        checkOutput("stall_hold", 64'({out_valid, frag_x, frag_y, sof, eol, eof}),
                    64'({1'b1, stall_snap}));
      if (!exp_valid) checkOutput("flags_gated", 64'({sof, eol, eof}), 64'(0));

      fire = exp_valid && out_ready && !frame_abort;
      if (fire) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL pixel actual=(%0d,%0d) required=none t=%0t", frag_x, frag_y, $time);
        end else begin
          item = sb.pop_front();
          checkOutput("pixel", 64'({frag_x, frag_y, sof, eol, eof}), 64'(item));
        end
      end
      stall_prev = out_valid && !out_ready && !frame_abort;
      stall_snap = {frag_x, frag_y, sof, eol, eof};

      if (frame_abort) begin
        m_active = 1'b0;
        m_issued = 0;
        m_out    = 0;
        sb.delete();
      end else if (!m_active) begin
        if (frame_req) begin
          m_active = 1'b1;
          m_issued = 0;
          m_out    = 0;
          sb.delete();
          for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
              sb.push_back('{16'(xx), 16'(yy), (xx == 0 && yy == 0), (xx == H - 1),
                             (xx == H - 1 && yy == V - 1)});
        end
      end else if (exp_done) begin
        checkOutput("sb_empty", 64'(sb.size()), 64'(0));
        m_active = 1'b0;
        m_cnt    = m_cnt + 16'd1;
      end else begin
        eol_fire = fire && ((m_issued % H) == H - 1);
        if (fire) m_issued++;
        if (eol_fire) m_out++;
        if (line_ack && m_out > 0) m_out--;
      end
    end
  end

  task automatic applyStimulus(input bit req, input bit abort, input bit ack, input bit rdy);
    bit eol_fire;
    frame_req   = req;
    frame_abort = abort;
    out_ready   = rdy;
    eol_fire    = out_valid && eol && rdy && !abort && rst_n;
    line_ack    = ack | ((ack_mode == 1) && ack_pipe[0]) | ((ack_mode == 2) && eol_fire);
    ack_pipe    = ack_pipe >> 1;
    if (ack_mode == 1 && eol_fire) ack_pipe[2] = 1'b1;
    if (abort) ack_pipe = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic runUntilDone(input bit rand_ready, input bit req_on_done, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      seen = frame_done;
      applyStimulus(req_on_done && frame_done, 1'b0, 1'b0,
                    rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL done_timeout actual=no_frame_done required=frame_done within %0d cycles", max_cycles);
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; frame_req = 1'b0; frame_abort = 1'b0; line_ack = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Full frame with delayed acks; extra ack at full credits, request while busy,
    // and a request coinciding with frame_done are all ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runUntilDone(1'b0, 1'b1, 100);
    idle(3);

    // Credit starvation: valid parks at (0,2) until a single ack arrives.
    ack_mode = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    idle(14);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    idle(6);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    runUntilDone(1'b0, 1'b0, 10);
    idle(2);

    ack_mode = 2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runUntilDone(1'b0, 1'b0, 60);
    idle(2);

    ack_mode = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runUntilDone(1'b1, 1'b0, 400);
    idle(2);

    // Abort while (2,1) is stalled, then restart from (0,0).
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (out_valid && frag_x == 16'd2 && frag_y == 16'd1) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL abort_point actual=not_reached required=(2,1)");
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idle(4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runUntilDone(1'b0, 1'b0, 100);
    idle(2);

    // One-cycle reset mid-scan clears everything including frame_cnt.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    idle(5);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    rst_n    = 1'b1;
    ack_pipe = '0;
    idle(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runUntilDone(1'b1, 1'b0, 400);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/viewport_frame_scheduler.md
Name: viewport_frame_scheduler

Overview:
- Frame-level controller that sequences the pixel-coordinate scan feeding the fragment pipeline.
- On a render request it issues one full H_DISP x V_DISP raster of fragment coordinates over a valid/ready handshake.
- Issue is paced by line credits returned from the downstream line buffer/framebuffer writer.
- Reports frame completion and counts frames; sits between the render control FSM and the fragment shading stage.

Parameters:
- H_DISP, 1280, active pixels per line
- V_DISP, 720, active lines per frame
- LINE_CREDITS, 2, max lines issued but not yet retired downstream (1..15)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- frame_req  in  1  start-frame pulse from render control
- frame_abort  in  1  abort the current frame
- line_ack  in  1  downstream retired one line; one-cycle pulse, returns one credit
- out_valid  out  1  fragment coordinate valid
- out_ready  in  1  downstream accepts coordinate
- frag_x  out  16  fragment x, 0..H_DISP-1
- frag_y  out  16  fragment y, 0..V_DISP-1
- sof  out  1  qualifies pixel (0,0)
- eol  out  1  qualifies x==H_DISP-1
- eof  out  1  qualifies last pixel of frame
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when a frame fully retires
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; x=y=0; credits=LINE_CREDITS; frame_cnt=0; out_valid, busy, frame_done, sof, eol and eof all 0.
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - out_valid=0.
  - frame_req=1 -> SCAN next cycle with x=y=0 and credits=LINE_CREDITS.
  - First out_valid appears the cycle after frame_req, giving 1-cycle latency.
- SCAN:
  - out_valid = (credits != 0).
  - A transfer occurs when out_valid & out_ready.
  - Non-eol transfer: x <= x+1.
  - eol transfer: x <= 0, y <= y+1, credits decrement.
  - eof transfer (x==H_DISP-1, y==V_DISP-1): also -> DRAIN; y is not incremented past V_DISP-1.
- Handshake stability: while out_valid=1 and out_ready=0, frag_x, frag_y, sof, eol and eof hold.
  - out_valid never drops without a transfer, except on abort or reset. Valid only gates off after an eol transfer has consumed the last credit.
- sof, eol and eof are combinational from the current x/y and are meaningful only while out_valid=1; they are 0 when out_valid=0.
- Credits:
  - line_ack increments credits.
  - line_ack in the same cycle as an eol transfer leaves credits unchanged.
  - line_ack when credits==LINE_CREDITS is ignored (saturate, no overflow).
  - line_ack in IDLE is ignored.
- DRAIN:
  - out_valid=0; waits until credits==LINE_CREDITS, i.e. every issued line has been acked.
  - In that cycle: frame_done=1 for one cycle, frame_cnt increments, -> IDLE.
  - A frame_req arriving in the same cycle as frame_done is ignored.
- frame_req while busy=1 is ignored; there is no queuing.
- frame_abort (any state, priority over frame_req and over transfers):
  - -> IDLE next cycle; out_valid=0; x=y=0; credits=LINE_CREDITS.
  - No frame_done; frame_cnt unchanged.
  - A transfer presented in the abort cycle is not counted.
- Reset mid-frame behaves identically to abort, and frame_cnt is also cleared.
- Arithmetic: x and y compare against H_DISP-1 and V_DISP-1 at 16-bit width; the credit counter is 4 bits.

Test Plan:
- H_DISP=4, V_DISP=3, LINE_CREDITS=2, out_ready=1, line_ack 3 cycles after each eol:
  - Required: 12 transfers in raster order (0,0)..(3,2); sof only on (0,0); eol on x=3; eof on (3,2).
  - Required: frame_done one pulse after the third line_ack; frame_cnt=1; busy falls the cycle after.
- Same config, no line_ack: out_valid drops after the second eol (at y=2, x=0) and stays low. One line_ack -> valid returns the next cycle with (0,2).
- Random out_ready backpressure: frag_x, frag_y and flags stay stable across every stalled cycle. A scoreboard sees exactly 12 unique coordinates, no duplicates and no gaps.
- frame_abort at (2,1) mid-stall: next cycle out_valid=0 and busy=0, no frame_done, frame_cnt unchanged. A new frame_req restarts at (0,0).
- Boundary events:
  - line_ack coincident with an eol transfer: credits unchanged.
  - Extra line_ack at full credits: credits stay at 2.
  - frame_req during SCAN: ignored.
  - frame_req coinciding with frame_done: ignored.
- rst_n=0 for 1 cycle mid-SCAN: all outputs at reset values the next cycle, frame_cnt=0. Running 65536 frames wraps frame_cnt to 0.
